// File: rtl/fft_operand_sequencer.sv
// Operand sequencer for a radix-2 FFT butterfly.
// A debounced push-button steps through loading the twiddle (Rew, Imw) and the
// two data points (Reb, Imb, Rea, Ima) from the switches. It then offers the
// set downstream with a valid/ready handshake, and finally walks four result
// selects for the LED stage. The twiddle is kept across sets, so each later
// set needs only four presses.
module fft_operand_sequencer #(
    parameter int n         = 8,
    parameter int DB_CYCLES = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         ReadyIn,
    input  logic [n-1:0] sw,
    output logic [n-1:0] Rew,
    output logic [n-1:0] Imw,
    output logic [n-1:0] Reb,
    output logic [n-1:0] Imb,
    output logic [n-1:0] Rea,
    output logic [n-1:0] Ima,
    output logic         OpValid,
    input  logic         OpReady,
    output logic [1:0]   DispIdx,
    output logic         DispStep,
    output logic         TwLoaded
);

    localparam int             CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        LD_REW, LD_IMW, LD_REB, LD_IMB, LD_REA, LD_IMA, ISSUE, DISP
    } state_t;

    state_t        state, state_nxt;
    logic          sync1, sync2;
    logic          db_level;
    logic [CW-1:0] db_cnt;
    logic          press;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge Clock) begin
        // NOTE: every sequential update uses <= so that all flops sample
        // pre-edge values; with = the second flop would see the first flop's
        // new value and the synchronizer would collapse to a single stage.
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ReadyIn;
            sync2 <= sync1;
        end
    end

    // Debounce: the level flips only after DB_CYCLES consecutive disagreeing
    // samples. A press pulse is raised on the edge where the level rises, so
    // the capture lands one cycle later.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync2;
                db_cnt   <= '0;
                press    <= sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= LD_REW;
        else       state <= state_nxt;
    end

    // Next-state logic: presses advance the load chain and the display walk;
    // the handshake moves ISSUE to DISP. Presses in ISSUE are dropped.
    always_comb begin
        // NOTE: the default assignment first guarantees every path assigns
        // state_nxt, so no latch is inferred for the unlisted cases.
        state_nxt = state;
        case (state)
            LD_REW: if (press) state_nxt = LD_IMW;
            LD_IMW: if (press) state_nxt = LD_REB;
            LD_REB: if (press) state_nxt = LD_IMB;
            LD_IMB: if (press) state_nxt = LD_REA;
            LD_REA: if (press) state_nxt = LD_IMA;
            LD_IMA: if (press) state_nxt = ISSUE;
            ISSUE:  if (OpReady) state_nxt = DISP;
            DISP:   if (press && DispIdx == 2'd3) state_nxt = LD_REB;
            default: state_nxt = LD_REW;
        endcase
    end

    // Operand capture: each register loads only on a press in its own state,
    // so nothing moves while the set is being offered in ISSUE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Rew      <= '0;
            Imw      <= '0;
            Reb      <= '0;
            Imb      <= '0;
            Rea      <= '0;
            Ima      <= '0;
            TwLoaded <= 1'b0;
        end else if (press) begin
            case (state)
                LD_REW: Rew <= sw;
                LD_IMW: begin
                    Imw      <= sw;
                    TwLoaded <= 1'b1;
                end
                LD_REB: Reb <= sw;
                LD_IMB: Imb <= sw;
                LD_REA: Rea <= sw;
                LD_IMA: Ima <= sw;
                default: ;
            endcase
        end
    end

    // Display select: cleared on the handshake, stepped by presses in DISP.
    // The 2-bit index wraps from 3 back to 0 as the FSM returns to LD_REB.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            DispIdx  <= 2'd0;
            DispStep <= 1'b0;
        end else begin
            DispStep <= 1'b0;
            if (state == ISSUE && OpReady) begin
                DispIdx <= 2'd0;
            end else if (state == DISP && press) begin
                DispStep <= 1'b1;
                DispIdx  <= DispIdx + 2'd1;
            end
        end
    end

    assign OpValid = (state == ISSUE);

endmodule

// File: tb/tb_fft_operand_sequencer.sv
// Directed bench for fft_operand_sequencer: load, issue, display, reload,
// bounce rejection and reset behaviour with hand-computed expectations.
module tb_fft_operand_sequencer;

    localparam int N  = 8;
    localparam int DB = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         ReadyIn = 1'b0;
    logic [N-1:0] sw = '0;
    logic         OpReady = 1'b0;
    logic [N-1:0] Rew, Imw, Reb, Imb, Rea, Ima;
    logic         OpValid, DispStep, TwLoaded;
    logic [1:0]   DispIdx;

    int n_checks = 0;
    int n_fail   = 0;
    int disp_cnt = 0;

    fft_operand_sequencer #(.n(N), .DB_CYCLES(DB)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .ReadyIn  (ReadyIn),
        .sw       (sw),
        .Rew      (Rew),
        .Imw      (Imw),
        .Reb      (Reb),
        .Imb      (Imb),
        .Rea      (Rea),
        .Ima      (Ima),
        .OpValid  (OpValid),
        .OpReady  (OpReady),
        .DispIdx  (DispIdx),
        .DispStep (DispStep),
        .TwLoaded (TwLoaded)
    );

    always #5 Clock = ~Clock;

    // Count DispStep high cycles, sampled away from the active edge.
    always @(negedge Clock) if (DispStep === 1'b1) disp_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Clean press: hold long enough to be accepted, then release long enough
    // for the debounced level to fall again.
    task automatic press(input logic [N-1:0] val);
        sw      = val;
        ReadyIn = 1'b1;
        repeat (DB + 6) @(negedge Clock);
        ReadyIn = 1'b0;
        repeat (DB + 6) @(negedge Clock);
    endtask

    task automatic handshake();
        OpReady = 1'b1;
        @(negedge Clock);
        OpReady = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge Clock);
        check("rst_rew", Rew, 0);
        check("rst_imw", Imw, 0);
        check("rst_reb", Reb, 0);
        check("rst_imb", Imb, 0);
        check("rst_rea", Rea, 0);
        check("rst_ima", Ima, 0);
        check("rst_opvalid", OpValid, 0);
        check("rst_dispidx", DispIdx, 0);
        check("rst_dispstep", DispStep, 0);
        check("rst_twloaded", TwLoaded, 0);
        Reset = 1'b0;
        @(negedge Clock);

        // First press with exact latency: event after 2+DB edges, value visible one later
        sw      = 8'h60;
        ReadyIn = 1'b1;
        repeat (DB + 2) @(negedge Clock);
        check("lat_rew_before", Rew, 0);
        @(negedge Clock);
        check("lat_rew_after", Rew, 8'h60);
        repeat (DB + 3) @(negedge Clock);
        ReadyIn = 1'b0;
        repeat (DB + 6) @(negedge Clock);
        check("tw_not_yet", TwLoaded, 0);

        press(8'hE0);
        check("tw_loaded", TwLoaded, 1);
        press(8'h06);
        press(8'h14);
        press(8'h07);

        // Sixth press: OpValid rises with the Ima capture
        sw      = 8'h01;
        ReadyIn = 1'b1;
        repeat (DB + 2) @(negedge Clock);
        check("opvalid_before_6th", OpValid, 0);
        @(negedge Clock);
        check("ima_6th", Ima, 8'h01);
        check("opvalid_after_6th", OpValid, 1);
        repeat (DB + 3) @(negedge Clock);
        ReadyIn = 1'b0;
        repeat (DB + 6) @(negedge Clock);

        check("set1_rew", Rew, 8'h60);
        check("set1_imw", Imw, 8'hE0);
        check("set1_reb", Reb, 8'h06);
        check("set1_imb", Imb, 8'h14);
        check("set1_rea", Rea, 8'h07);
        check("set1_ima", Ima, 8'h01);

        // Switch changes without a press, and a press during ISSUE, do nothing
        sw = 8'hFF;
        repeat (5) @(negedge Clock);
        check("issue_hold_opvalid", OpValid, 1);
        check("issue_hold_reb", Reb, 8'h06);
        press(8'h33);
        check("issue_press_opvalid", OpValid, 1);
        check("issue_press_rew", Rew, 8'h60);
        check("issue_press_ima", Ima, 8'h01);
        check("issue_press_nostep", disp_cnt, 0);

        // Handshake into DISP
        handshake();
        check("hs_opvalid", OpValid, 0);
        check("hs_dispidx", DispIdx, 0);

        // OpReady outside ISSUE has no effect
        handshake();
        check("stray_ready_idx", DispIdx, 0);
        check("stray_ready_opvalid", OpValid, 0);

        // Four display presses
        press(8'h00);
        check("disp1_idx", DispIdx, 1);
        check("disp1_cnt", disp_cnt, 1);
        press(8'h00);
        check("disp2_idx", DispIdx, 2);
        press(8'h00);
        check("disp3_idx", DispIdx, 3);
        press(8'h00);
        check("disp4_idx", DispIdx, 0);
        check("disp4_cnt", disp_cnt, 4);

        // Second set: four presses, twiddle retained
        press(8'h07);
        check("set2_reb_first", Reb, 8'h07);
        press(8'h84);
        press(8'h06);
        press(8'h02);
        check("set2_reb", Reb, 8'h07);
        check("set2_imb", Imb, 8'h84);
        check("set2_rea", Rea, 8'h06);
        check("set2_ima", Ima, 8'h02);
        check("set2_rew", Rew, 8'h60);
        check("set2_imw", Imw, 8'hE0);
        check("set2_opvalid", OpValid, 1);
        check("set2_nostep", disp_cnt, 4);

        // Back to LD_REB
        handshake();
        repeat (4) press(8'h00);
        check("disp_round2_idx", DispIdx, 0);
        check("disp_round2_cnt", disp_cnt, 8);

        // Short pulse then bounce: no capture; stable high then captures once
        sw      = 8'h5A;
        ReadyIn = 1'b1;
        repeat (DB - 1) @(negedge Clock);
        for (int i = 0; i < 50; i++) begin
            ReadyIn = ((i / 3) % 2 == 1);
            @(negedge Clock);
        end
        check("bounce_no_capture", Reb, 8'h07);
        ReadyIn = 1'b1;
        repeat (DB + 6) @(negedge Clock);
        check("bounce_capture_reb", Reb, 8'h5A);
        check("bounce_imb_untouched", Imb, 8'h84);
        ReadyIn = 1'b0;
        repeat (DB + 6) @(negedge Clock);
        press(8'h99);
        check("bounce_single_imb", Imb, 8'h99);
        check("bounce_single_rea", Rea, 8'h06);

        // Reset mid-load with the button held through release
        sw      = 8'h11;
        ReadyIn = 1'b1;
        Reset   = 1'b1;
        repeat (3) @(negedge Clock);
        check("rst2_rew", Rew, 0);
        check("rst2_imw", Imw, 0);
        check("rst2_reb", Reb, 0);
        check("rst2_imb", Imb, 0);
        check("rst2_twloaded", TwLoaded, 0);
        check("rst2_opvalid", OpValid, 0);
        check("rst2_dispidx", DispIdx, 0);
        Reset = 1'b0;
        repeat (DB + 2) @(negedge Clock);
        check("held_rew_before", Rew, 0);
        @(negedge Clock);
        check("held_rew_after", Rew, 8'h11);
        repeat (20) @(negedge Clock);
        check("held_single_imw", Imw, 0);
        ReadyIn = 1'b0;
        repeat (DB + 6) @(negedge Clock);
        press(8'h22);
        check("post_rst_imw", Imw, 8'h22);
        check("post_rst_tw", TwLoaded, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
